dec3_8_scan_seq: RTL and testbench

//   Upstream driver for the 3-to-8 decoder: generates its 3-bit select X.

---
 rtl/dec3_8_scan_seq.sv | 109 ++++++++++
 tb/tb_dec3_8_scan_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dec3_8_scan_seq.sv
// Select-line sequencer for a 3-to-8 decoder: sweeps sel through 0..7 (up or down)
// with a programmable per-position dwell, in one-shot, continuous, stop and single-step modes.
module dec3_8_scan_seq #(
  parameter int DW   = 16,
  parameter int NPOS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          step,
  input  logic          dir,
  input  logic          cont,
  input  logic [DW-1:0] dwell,
  output logic [2:0]    sel,
  output logic          sel_vld,
  output logic          busy,
  output logic          sweep_done
);

  localparam logic [2:0] TOP_POS = 3'(NPOS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] dwell_q;
  logic          dir_q;
  logic          cont_q;
  logic [2:0]    first_pos;
  logic [2:0]    last_pos;
  logic [2:0]    start_pos;

  // Sweep end points follow the latched direction; a fresh start uses the live one.
  assign first_pos = dir_q ? TOP_POS : 3'd0;
  assign last_pos  = dir_q ? 3'd0 : TOP_POS;
  assign start_pos = dir ? TOP_POS : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 3'd0;
      sel_vld    <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      cnt        <= '0;
      dwell_q    <= '0;
      dir_q      <= 1'b0;
      cont_q     <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (stop) begin
            sel_vld <= 1'b0;
          end else if (start) begin
            state   <= RUN;
            sel     <= start_pos;
            cnt     <= '0;
            busy    <= 1'b1;
            sel_vld <= 1'b1;
            dir_q   <= dir;
            cont_q  <= cont;
            dwell_q <= dwell;
          end else if (step) begin
            sel     <= dir ? sel - 3'd1 : sel + 3'd1;
            sel_vld <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sel_vld <= 1'b0;
          end else if (start) begin
            sel     <= start_pos;
            cnt     <= '0;
            sel_vld <= 1'b1;
            dir_q   <= dir;
            cont_q  <= cont;
            dwell_q <= dwell;
          end else if (cnt == dwell_q) begin
            cnt <= '0;
            // Last position expired: wrap in continuous mode, otherwise finish the sweep.
            if (sel == last_pos) begin
              if (cont_q) begin
                sel <= first_pos;
              end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                sel_vld    <= 1'b0;
                sweep_done <= 1'b1;
              end
            end else begin
              sel <= dir_q ? sel - 3'd1 : sel + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec3_8_scan_seq.sv
// Bench for dec3_8_scan_seq: a sweep-index model checked every cycle, plus directed
// scenarios with hand-computed expectations for timing, wrap, stop, step and restart.
module tb_dec3_8_scan_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] dwell = 16'd0;
  logic [2:0]  sel;
  logic        sel_vld;
  logic        busy;
  logic        sweep_done;

  int errors = 0;
  int checks = 0;

  dec3_8_scan_seq #(.DW(16), .NPOS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .dir        (dir),
    .cont       (cont),
    .dwell      (dwell),
    .sel        (sel),
    .sel_vld    (sel_vld),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position index k walks 0..7 along the sweep; sel is k or 7-k depending on direction.
  int m_k = 0, m_hold = 0, m_dwell = 0, m_sel = 0;
  bit m_dir = 0, m_cont = 0, m_busy = 0, m_vld = 0, m_done = 0;

  function automatic void m_begin();
    m_k     = 0;
    m_hold  = 0;
    m_dir   = dir;
    m_cont  = cont;
    m_dwell = int'(dwell);
    m_busy  = 1;
    m_vld   = 1;
    m_sel   = m_dir ? 7 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_hold = 0; m_dwell = 0; m_sel = 0;
      m_dir = 0; m_cont = 0; m_busy = 0; m_vld = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (stop) begin
          m_busy = 0;
          m_vld  = 0;
        end else if (start) begin
          m_begin();
        end else if (m_hold == m_dwell) begin
          m_hold = 0;
          if (m_k == 7) begin
            if (m_cont) m_k = 0;
            else begin
              m_busy = 0;
              m_vld  = 0;
              m_done = 1;
            end
          end else begin
            m_k++;
          end
          m_sel = m_dir ? 7 - m_k : m_k;
        end else begin
          m_hold++;
        end
      end else begin
        if (stop) m_vld = 0;
        else if (start) m_begin();
        else if (step) begin
          m_sel = (m_sel + (dir ? 7 : 1)) % 8;
          m_vld = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, including the decoder one-hot view of sel.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("sel", 32'(sel), 32'(m_sel));
      checkOutput("sel_vld", 32'(sel_vld), 32'(m_vld));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("sweep_done", 32'(sweep_done), 32'(m_done));
      if (m_vld) checkOutput("decoder_y", 32'(8'd1 << sel), 32'(8'd1 << m_sel[2:0]));
    end
  end

  // Drives a one-cycle command starting at the current negedge.
  task automatic applyStimulus(input logic s, input logic p, input logic st);
    start = s;
    stop  = p;
    step  = st;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    step  = 1'b0;
  endtask

  task automatic waitDone(input int bound, output int n);
    n = 0;
    while (sweep_done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitSel(input logic [2:0] val, input int bound);
    int n = 0;
    while (sel !== val && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_sel", 32'(sel), 32'(val));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] step_exp [9];
    step_exp = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

    repeat (3) @(negedge clk);
    checkOutput("reset_sel", 32'(sel), 0);
    checkOutput("reset_vld", 32'(sel_vld), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] async reset mid-sweep");
    dir = 1'b0; dwell = 16'd3; cont = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_sel", 32'(sel), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_sel", 32'(sel), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_vld", 32'(sel_vld), 0);
    checkOutput("async_done", 32'(sweep_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] one-shot up sweep, dwell 0");
    dir = 1'b0; dwell = 16'd0; cont = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("up_sel0", 32'(sel), 0);
    checkOutput("up_busy", 32'(busy), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checkOutput("up_seq", 32'(sel), 32'(i));
    end
    @(negedge clk);
    checkOutput("up_done", 32'(sweep_done), 1);
    checkOutput("up_end_busy", 32'(busy), 0);
    checkOutput("up_end_sel", 32'(sel), 7);
    @(negedge clk);
    checkOutput("up_done_once", 32'(sweep_done), 0);

    $display("[TB] one-shot down sweep, dwell 2");
    dir = 1'b1; dwell = 16'd2; cont = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    dir = 1'b0; dwell = 16'd0;
    checkOutput("down_sel0", 32'(sel), 7);
    waitDone(200, n);
    checkOutput("down_length", 32'(n), 24);
    checkOutput("down_end_sel", 32'(sel), 0);
    @(negedge clk);

    $display("[TB] continuous up, dwell 1, then stop at 4");
    dir = 1'b0; dwell = 16'd1; cont = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitSel(3'd7, 40);
    waitSel(3'd0, 40);
    checkOutput("wrap_busy", 32'(busy), 1);
    waitSel(3'd4, 40);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_sel", 32'(sel), 4);
    checkOutput("stop_vld", 32'(sel_vld), 0);

    $display("[TB] idle single-step");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("step_to6", 32'(sel), 6);
    for (int i = 0; i < 9; i++) begin
      step = 1'b1;
      @(negedge clk);
      checkOutput("step_seq", 32'(sel), 32'(step_exp[i]));
      checkOutput("step_busy", 32'(busy), 0);
    end
    step = 1'b0;
    checkOutput("step_vld", 32'(sel_vld), 1);
    dir = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("step_down", 32'(sel), 6);
    dir = 1'b0;

    $display("[TB] start+stop together, restart in RUN");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("startstop_busy", 32'(busy), 0);
    checkOutput("startstop_sel", 32'(sel), 6);
    dir = 1'b0; dwell = 16'd0; cont = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitSel(3'd5, 20);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_sel", 32'(sel), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    waitDone(100, n);
    checkOutput("restart_length", 32'(n), 8);
    repeat (2) @(negedge clk);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
